vram_arb: RTL and testbench

- Initiator side of the 16-bit, 64K-word single-port video RAM.
- Arbitrates each cycle between the video display fetch port and the host register port, then drives the VRAM strobes.
- Returns read data with fixed latency, based on the VRAM's 1-cycle registered read.
- Video has priority, but a bounded-wait counter stops the host from being starved.

---
 rtl/vram_arb.sv | 146 ++++++++++++++
 tb/tb_vram_arb.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arb.sv
// Video RAM initiator: arbitrates video fetch vs. host register accesses onto a
// single-port 16-bit VRAM and returns read data with a fixed 3-cycle latency.
module vram_arb #(
    parameter int unsigned MAX_HOST_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic        vid_ack,
    output logic        vid_data_valid,
    output logic [15:0] vid_data,

    input  logic        host_req,
    input  logic        host_wr,
    input  logic [15:0] host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_busy,
    output logic        host_rd_valid,
    output logic [15:0] host_rdata,

    output logic        vram_sel,
    output logic        vram_wr_en,
    output logic [15:0] vram_addr,
    output logic [15:0] vram_wdata,
    input  logic [15:0] vram_rdata
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_HOST_WAIT);

    typedef enum logic {
        HOST_IDLE,
        HOST_PEND
    } host_state_t;

    host_state_t host_state, host_state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic        pend_wr;
    logic [15:0] pend_addr;
    logic [15:0] pend_wdata;

    logic        pending;
    logic        force_host;
    logic        grant_vid;
    logic        grant_host;
    logic        accept;

    logic [1:0]  vid_tag;
    logic [1:0]  host_tag;

    // Grant and host-request state; a request latched this cycle only shows
    // up as pending next cycle, so it can never win its own accept cycle.
    always_comb begin
        pending        = (host_state == HOST_PEND);
        force_host     = pending && (wait_cnt == WAIT_MAX);
        grant_vid      = vid_req && !force_host;
        grant_host     = pending && !grant_vid;
        accept         = host_req && !pending;
        host_state_nxt = host_state;
        wait_cnt_nxt   = wait_cnt;
        case (host_state)
            HOST_IDLE: begin
                wait_cnt_nxt = '0;
                if (host_req) host_state_nxt = HOST_PEND;
            end
            HOST_PEND: begin
                if (grant_host) begin
                    host_state_nxt = HOST_IDLE;
                    wait_cnt_nxt   = '0;
                end else if (wait_cnt != WAIT_MAX) begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            default: begin
                host_state_nxt = HOST_IDLE;
                wait_cnt_nxt   = '0;
            end
        endcase
    end

    assign vid_ack   = grant_vid && reset_n;
    assign host_busy = pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            host_state <= HOST_IDLE;
            wait_cnt   <= '0;
            pend_wr    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
        end else begin
            host_state <= host_state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            if (accept) begin
                pend_wr    <= host_wr;
                pend_addr  <= host_addr;
                pend_wdata <= host_wdata;
            end
        end
    end

    // VRAM slot: address/data hold through idle slots.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vram_sel   <= 1'b0;
            vram_wr_en <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
        end else begin
            vram_sel   <= grant_vid || grant_host;
            vram_wr_en <= grant_host && pend_wr;
            if (grant_vid) begin
                vram_addr <= vid_addr;
            end else if (grant_host) begin
                vram_addr  <= pend_addr;
                vram_wdata <= pend_wdata;
            end
        end
    end

    // Read tags ride alongside the slot; rdata arrives two cycles after grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_tag        <= '0;
            host_tag       <= '0;
            vid_data_valid <= 1'b0;
            vid_data       <= '0;
            host_rd_valid  <= 1'b0;
            host_rdata     <= '0;
        end else begin
            vid_tag        <= {vid_tag[0], grant_vid};
            host_tag       <= {host_tag[0], grant_host && !pend_wr};
            vid_data_valid <= vid_tag[1];
            host_rd_valid  <= host_tag[1];
            if (vid_tag[1])  vid_data   <= vram_rdata;
            if (host_tag[1]) host_rdata <= vram_rdata;
        end
    end

    a_wr_implies_sel: assert property (@(posedge clk) disable iff (!reset_n)
        vram_wr_en |-> vram_sel);
    a_one_winner: assert property (@(posedge clk) disable iff (!reset_n)
        !(grant_vid && grant_host));

endmodule

// File: tb/tb_vram_arb.sv
// Randomized scoreboard bench for vram_arb with a transaction-level VRAM and
// arbitration reference model.
module tb_vram_arb;

    localparam int unsigned MAX = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic        vid_data_valid;
    logic [15:0] vid_data;
    logic        host_req;
    logic        host_wr;
    logic [15:0] host_addr;
    logic [15:0] host_wdata;
    logic        host_busy;
    logic        host_rd_valid;
    logic [15:0] host_rdata;
    logic        vram_sel;
    logic        vram_wr_en;
    logic [15:0] vram_addr;
    logic [15:0] vram_wdata;
    logic [15:0] vram_rdata = '0;

    vram_arb #(.MAX_HOST_WAIT(MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_data_valid(vid_data_valid), .vid_data(vid_data),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_busy(host_busy),
        .host_rd_valid(host_rd_valid), .host_rdata(host_rdata),
        .vram_sel(vram_sel), .vram_wr_en(vram_wr_en), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_word(input logic [15:0] a);
        if (a == 16'h1234) return 16'hA5A5;
        return (a * 16'h9E37) ^ 16'h3C5A;
    endfunction

    // VRAM: 1-cycle registered read, write on sel & wr_en.
    logic [15:0] vmem [0:65535];
    bit          vwritten [0:65535];
    always @(posedge clk) begin
        if (vram_sel) begin
            if (vram_wr_en) begin
                vmem[vram_addr]     <= vram_wdata;
                vwritten[vram_addr] <= 1'b1;
            end else begin
                vram_rdata <= vwritten[vram_addr] ? vmem[vram_addr] : init_word(vram_addr);
            end
        end
    end

    typedef struct { int unsigned cyc; logic [15:0] data; } rd_exp_t;
    typedef struct { int unsigned cyc; logic sel; logic wr; logic [15:0] addr; logic [15:0] wdata; } slot_exp_t;
    typedef struct { int unsigned cyc; logic ack; logic busy; } arb_exp_t;

    rd_exp_t   vid_q[$];
    rd_exp_t   host_q[$];
    slot_exp_t slot_q[$];
    arb_exp_t  arb_q[$];

    // Reference model: memory contents as seen in grant order.
    logic [15:0] ref_mem [int unsigned];
    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    logic        m_pend, m_wr, gh, gv, was;
    logic [15:0] m_haddr, m_hwdata, m_addr, m_wdata;
    int unsigned m_wait;

    // Rules: host wins when it has lost MAX times or video is idle; results
    // appear three cycles after the winning cycle.
    initial begin
        m_pend = 0; m_wr = 0; m_wait = 0;
        m_haddr = '0; m_hwdata = '0; m_addr = '0; m_wdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n) begin
                vid_q.delete(); host_q.delete(); slot_q.delete(); arb_q.delete();
                m_pend = 0; m_wait = 0; m_addr = '0; m_wdata = '0;
                slot_q.push_back('{cyc + 1, 1'b0, 1'b0, 16'h0, 16'h0});
            end else begin
                gh = m_pend && (m_wait == MAX || !vid_req);
                gv = vid_req && !gh;
                arb_q.push_back('{cyc, gv, m_pend});
                if (gv) begin
                    m_addr = vid_addr;
                    vid_q.push_back('{cyc + 3, ref_rd(vid_addr)});
                end
                if (gh) begin
                    m_addr = m_haddr;
                    if (m_wr) begin
                        m_wdata = m_hwdata;
                        ref_mem[int'(m_haddr)] = m_hwdata;
                    end else begin
                        host_q.push_back('{cyc + 3, ref_rd(m_haddr)});
                    end
                end
                slot_q.push_back('{cyc + 1, gv || gh, gh && m_wr, m_addr, m_wdata});
                if (!m_pend || gh) m_wait = 0;
                else if (m_wait < MAX) m_wait = m_wait + 1;
                was = m_pend;
                if (gh) m_pend = 0;
                if (host_req && !was) begin
                    m_pend = 1; m_wr = host_wr; m_haddr = host_addr; m_hwdata = host_wdata;
                end
            end
        end
    end

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations as their cycle comes up, away from posedge.
    initial begin
        rd_exp_t     r;
        slot_exp_t   s;
        arb_exp_t    a;
        logic        exp_v;
        logic [15:0] hold_vid, hold_host;
        hold_vid = '0; hold_host = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("reset_outputs", {vid_ack, vid_data_valid, vid_data, host_busy, host_rd_valid,
                      host_rdata, vram_sel, vram_wr_en, vram_addr, vram_wdata}, '0);
                hold_vid = '0; hold_host = '0;
                while (slot_q.size() > 0 && slot_q[0].cyc <= cyc) void'(slot_q.pop_front());
                while (arb_q.size() > 0 && arb_q[0].cyc <= cyc) void'(arb_q.pop_front());
            end else begin
                if (arb_q.size() > 0 && arb_q[0].cyc == cyc) begin
                    a = arb_q.pop_front();
                    check("vid_ack", vid_ack, a.ack);
                    check("host_busy", host_busy, a.busy);
                end
                if (slot_q.size() > 0 && slot_q[0].cyc == cyc) begin
                    s = slot_q.pop_front();
                    check("vram_sel", vram_sel, s.sel);
                    check("vram_wr_en", vram_wr_en, s.wr);
                    check("vram_addr", vram_addr, s.addr);
                    if (s.wr) check("vram_wdata", vram_wdata, s.wdata);
                end
                exp_v = vid_q.size() > 0 && vid_q[0].cyc == cyc;
                check("vid_data_valid", vid_data_valid, exp_v);
                if (exp_v) begin
                    r = vid_q.pop_front();
                    check("vid_data", vid_data, r.data);
                    hold_vid = r.data;
                end else begin
                    check("vid_data_hold", vid_data, hold_vid);
                end
                exp_v = host_q.size() > 0 && host_q[0].cyc == cyc;
                check("host_rd_valid", host_rd_valid, exp_v);
                if (exp_v) begin
                    r = host_q.pop_front();
                    check("host_rdata", host_rdata, r.data);
                    hold_host = r.data;
                end else begin
                    check("host_rdata_hold", host_rdata, hold_host);
                end
            end
        end
    end

    // Stimulus: changes inputs 1 ns after each posedge.
    task automatic tick(output logic ack);
        @(negedge clk);
        ack = vid_ack;
        @(posedge clk);
        #1;
        host_req = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        logic ack;
        for (int unsigned i = 0; i < n; i++) tick(ack);
    endtask

    task automatic host_op(input logic wr, input logic [15:0] a, input logic [15:0] d);
        host_req = 1'b1; host_wr = wr; host_addr = a; host_wdata = d;
    endtask

    task automatic vid_stream(input int unsigned n);
        logic ack;
        vid_req = 1'b1;
        for (int unsigned i = 0; i < n; i++) begin
            tick(ack);
            if (ack) vid_addr = vid_addr + 16'd1;
        end
    endtask

    initial begin
        logic        ack;
        int unsigned n;
        int unsigned guard;
        logic [15:0] ra;
        reset_n = 1'b0; vid_req = 1'b0; vid_addr = '0;
        host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
        idle(3);
        reset_n = 1'b1;
        idle(2);

        host_op(1'b0, 16'h1234, 16'h0); idle(1); idle(6);
        host_op(1'b1, 16'h4000, 16'hBEEF); idle(1); idle(4);
        host_op(1'b0, 16'h4000, 16'h0); idle(1); idle(6);

        // Eight back-to-back video fetches, addresses 0..7.
        vid_req = 1'b1; vid_addr = '0; n = 0; guard = 0;
        while (n < 8 && guard < 40) begin
            tick(ack);
            guard++;
            if (ack) begin
                n++;
                vid_addr = 16'(n);
                if (n == 8) vid_req = 1'b0;
            end
        end
        vid_req = 1'b0;
        idle(6);

        // Host read under continuous video: forced slot after MAX losses.
        vid_addr = 16'd100;
        vid_stream(2);
        host_op(1'b0, 16'h4000, 16'h0);
        vid_stream(12);

        // Second request while busy must be dropped.
        host_op(1'b0, 16'h1234, 16'h0);
        vid_stream(1);
        host_op(1'b0, 16'h5555, 16'h0);
        vid_stream(10);
        vid_req = 1'b0;
        idle(8);

        // Reset one cycle after the host read's slot.
        host_op(1'b0, 16'h1234, 16'h0);
        idle(3);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(8);
        host_op(1'b0, 16'h4000, 16'h0); idle(1); idle(6);

        for (int unsigned i = 0; i < 3000; i++) begin
            if (!vid_req && $urandom_range(0, 99) < 60) begin
                vid_req = 1'b1;
                vid_addr = 16'($urandom_range(0, 63));
                if ($urandom_range(0, 3) == 0) vid_addr = vid_addr | 16'hFFC0;
            end
            if ($urandom_range(0, 99) < 25) begin
                ra = 16'($urandom_range(0, 63));
                if ($urandom_range(0, 3) == 0) ra = ra | 16'hFFC0;
                host_op(1'($urandom_range(0, 1)), ra, 16'($urandom));
            end
            tick(ack);
            if (ack) vid_req = 1'b0;
        end
        vid_req = 1'b0;
        idle(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
